// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline hazard and sequencing controller for the 5-stage core.
// Resolves EX-stage forwarding, load-use stalls and taken-branch flushes. It freezes
// the whole pipeline while a data-memory access is pending and raises a fault if the
// access times out. It also keeps stall and flush performance counters.
module hazard_sequencer #(
   parameter int TIMEOUT = 16,   // max MEM_WAIT cycles before faulting (1..255)
   parameter int CNT_W   = 32    // performance counter width
) (
   input  logic             clk,
   input  logic             reset,
   // Decode stage
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   // Execute stage
   input  logic [4:0]       rs1_e,
   input  logic [4:0]       rs2_e,
   input  logic [4:0]       rd_e,
   input  logic [1:0]       result_src_e,
   input  logic             pcsrc_e,
   // Memory stage
   input  logic [4:0]       rd_m,
   input  logic             regwrite_m,
   input  logic             dmem_valid_m,
   input  logic             dmem_ready,
   // Writeback stage
   input  logic [4:0]       rd_w,
   input  logic             regwrite_w,
   // Fault handling
   input  logic             fault_clr,
   // Pipeline register controls
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             flush_d,
   output logic             flush_e,
   output logic             flush_w,
   // Forwarding selects: 00 register file, 01 writeback, 10 memory
   output logic [1:0]       forward_a_e,
   output logic [1:0]       forward_b_e,
   // Status and counters
   output logic             mem_fault,
   output logic             busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      FAULT    = 2'b10
   } state_t;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;
   localparam logic [1:0] RES_LOAD = 2'b01;
   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t     state;
   logic [7:0] wait_cnt;
   logic       lw_stall;
   logic       mem_hold;
   logic       freeze;

   // Forwarding: the younger (memory-stage) producer wins over writeback; x0 is never forwarded.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      forward_a_e = FWD_NONE;
      forward_b_e = FWD_NONE;
      if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs1_e))
         forward_a_e = FWD_MEM;
      else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs1_e))
         forward_a_e = FWD_WB;
      if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs2_e))
         forward_b_e = FWD_MEM;
      else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs2_e))
         forward_b_e = FWD_WB;
   end

   // Hazard detection terms, all from this cycle's inputs.
   assign lw_stall = (result_src_e == RES_LOAD) && (rd_e != 5'd0) &&
                     ((rd_e == rs1_d) || (rd_e == rs2_d));
   assign mem_hold = dmem_valid_m && !dmem_ready;
   assign freeze   = mem_hold || (state == FAULT);

   // Stall/flush priority: memory freeze, then taken branch, then load-use.
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b0;
      if (freeze) begin
         // Whole pipeline held; the EX instruction is re-evaluated once memory completes.
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
      end else if (pcsrc_e) begin
         // Decode holds a wrong-path instruction, so its load-use hazard is irrelevant.
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (lw_stall) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   // Memory-wait FSM with registered busy flag and one-cycle timeout pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         wait_cnt  <= 8'd0;
         mem_fault <= 1'b0;
         busy      <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         mem_fault <= 1'b0;
         case (state)
            RUN: begin
               if (mem_hold) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= 8'd1;
                  busy     <= 1'b1;
               end
            end
            MEM_WAIT: begin
               if (dmem_ready) begin
                  state    <= RUN;
                  wait_cnt <= 8'd0;
                  busy     <= 1'b0;
               end else if (wait_cnt == TIMEOUT_C) begin
                  state     <= FAULT;
                  mem_fault <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            FAULT: begin
               if (fault_clr) begin
                  state    <= RUN;
                  wait_cnt <= 8'd0;
                  busy     <= 1'b0;
               end
            end
            default: begin
               state    <= RUN;
               wait_cnt <= 8'd0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

   // Performance counters: stall cycles and branch/jump flush events, wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_f)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_d)
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed self-checking bench for hazard_sequencer (TIMEOUT=4).
module tb_hazard_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic [1:0]  result_src_e;
   logic        pcsrc_e, regwrite_m, dmem_valid_m, dmem_ready, regwrite_w, fault_clr;
   logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
   logic [1:0]  forward_a_e, forward_b_e;
   logic        mem_fault, busy;
   logic [31:0] stall_cnt, flush_cnt;
   logic [6:0]  ctl;

   int n_checks = 0;
   int n_fail   = 0;

   // Control vector order: stall_f stall_d stall_e stall_m flush_d flush_e flush_w
   localparam logic [6:0] CTL_NONE   = 7'b0000000;
   localparam logic [6:0] CTL_FREEZE = 7'b1111001;
   localparam logic [6:0] CTL_BRANCH = 7'b0000110;
   localparam logic [6:0] CTL_LOAD   = 7'b1100010;

   assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};

   hazard_sequencer #(.TIMEOUT(4), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .rs1_d(rs1_d), .rs2_d(rs2_d),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .result_src_e(result_src_e), .pcsrc_e(pcsrc_e),
      .rd_m(rd_m), .regwrite_m(regwrite_m), .dmem_valid_m(dmem_valid_m), .dmem_ready(dmem_ready),
      .rd_w(rd_w), .regwrite_w(regwrite_w), .fault_clr(fault_clr),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .mem_fault(mem_fault), .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
      result_src_e = 2'b00; pcsrc_e = 0; regwrite_m = 0; dmem_valid_m = 0;
      dmem_ready = 0; regwrite_w = 0; fault_clr = 0;
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic at_sample();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      #12;
      check("rst_ctl", 32'(ctl), 32'(CTL_NONE));
      check("rst_fwd", 32'({forward_a_e, forward_b_e}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fault", 32'(mem_fault), 32'd0);
      check("rst_stall_cnt", stall_cnt, 32'd0);
      check("rst_flush_cnt", flush_cnt, 32'd0);
      reset = 1'b0;

      // Forwarding
      next_cycle();
      regwrite_m = 1; rd_m = 5; rs1_e = 5; regwrite_w = 1; rd_w = 5; rs2_e = 7;
      at_sample();
      check("fwd_a_mem_wins", 32'(forward_a_e), 32'd2);
      check("fwd_b_nomatch", 32'(forward_b_e), 32'd0);
      check("fwd_ctl", 32'(ctl), 32'(CTL_NONE));
      next_cycle();
      rd_m = 0;
      at_sample();
      check("fwd_a_wb", 32'(forward_a_e), 32'd1);
      next_cycle();
      rd_m = 5; regwrite_m = 0; rs1_e = 9; rs2_e = 5;
      at_sample();
      check("fwd_a_none", 32'(forward_a_e), 32'd0);
      check("fwd_b_wb", 32'(forward_b_e), 32'd1);
      next_cycle();
      regwrite_m = 1; rd_m = 0; rd_w = 0; rs1_e = 0; rs2_e = 0;
      at_sample();
      check("fwd_x0", 32'({forward_a_e, forward_b_e}), 32'd0);

      // Load-use
      next_cycle();
      clear_inputs();
      result_src_e = 2'b01; rd_e = 3; rs2_d = 3;
      at_sample();
      check("lw_ctl", 32'(ctl), 32'(CTL_LOAD));
      check("lw_cnt_before", stall_cnt, 32'd0);
      next_cycle();
      result_src_e = 2'b00;
      at_sample();
      check("lw_release_ctl", 32'(ctl), 32'(CTL_NONE));
      check("lw_cnt_after", stall_cnt, 32'd1);
      next_cycle();
      result_src_e = 2'b01; rd_e = 0; rs2_d = 0;
      at_sample();
      check("lw_x0_ctl", 32'(ctl), 32'(CTL_NONE));

      // Branch flush suppresses load-use
      next_cycle();
      rd_e = 3; rs2_d = 3; pcsrc_e = 1;
      at_sample();
      check("br_ctl", 32'(ctl), 32'(CTL_BRANCH));
      next_cycle();
      clear_inputs();
      at_sample();
      check("br_flush_cnt", flush_cnt, 32'd1);
      check("br_stall_cnt", stall_cnt, 32'd1);

      // Memory wait: three not-ready cycles then ready; branch ignored while frozen
      next_cycle();
      dmem_valid_m = 1; pcsrc_e = 1;
      at_sample();
      check("mw1_ctl", 32'(ctl), 32'(CTL_FREEZE));
      check("mw1_busy", 32'(busy), 32'd0);
      next_cycle();
      pcsrc_e = 0;
      at_sample();
      check("mw2_ctl", 32'(ctl), 32'(CTL_FREEZE));
      check("mw2_busy", 32'(busy), 32'd1);
      next_cycle();
      at_sample();
      check("mw3_busy", 32'(busy), 32'd1);
      next_cycle();
      dmem_ready = 1;
      at_sample();
      check("mw4_ctl", 32'(ctl), 32'(CTL_NONE));
      check("mw4_busy", 32'(busy), 32'd1);
      check("mw4_stall_cnt", stall_cnt, 32'd4);
      next_cycle();
      clear_inputs();
      at_sample();
      check("mw5_busy", 32'(busy), 32'd0);
      check("mw5_flush_cnt", flush_cnt, 32'd1);

      // Ready arrives with valid: no stall, FSM stays in RUN
      next_cycle();
      dmem_valid_m = 1; dmem_ready = 1;
      at_sample();
      check("same_ctl", 32'(ctl), 32'(CTL_NONE));
      next_cycle();
      clear_inputs();
      at_sample();
      check("same_busy", 32'(busy), 32'd0);
      check("same_stall_cnt", stall_cnt, 32'd4);

      // Timeout with TIMEOUT=4: fault pulse after the fifth not-ready cycle
      next_cycle();
      dmem_valid_m = 1;
      at_sample();
      check("to1_ctl", 32'(ctl), 32'(CTL_FREEZE));
      for (int i = 2; i <= 5; i++) begin
         next_cycle();
         at_sample();
         check("to_wait_busy", 32'(busy), 32'd1);
         check("to_wait_fault", 32'(mem_fault), 32'd0);
      end
      next_cycle();
      dmem_valid_m = 0;
      at_sample();
      check("to6_fault", 32'(mem_fault), 32'd1);
      check("to6_ctl", 32'(ctl), 32'(CTL_FREEZE));
      check("to6_busy", 32'(busy), 32'd1);
      next_cycle();
      fault_clr = 1;
      at_sample();
      check("to7_fault", 32'(mem_fault), 32'd0);
      check("to7_ctl", 32'(ctl), 32'(CTL_FREEZE));
      next_cycle();
      fault_clr = 0;
      at_sample();
      check("to8_busy", 32'(busy), 32'd0);
      check("to8_ctl", 32'(ctl), 32'(CTL_NONE));
      check("to8_stall_cnt", stall_cnt, 32'd11);

      // Asynchronous reset mid-wait
      next_cycle();
      dmem_valid_m = 1;
      next_cycle();
      #2;
      check("ar_pre_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_fault", 32'(mem_fault), 32'd0);
      check("ar_stall_cnt", stall_cnt, 32'd0);
      check("ar_flush_cnt", flush_cnt, 32'd0);
      dmem_valid_m = 0;
      at_sample();
      reset = 1'b0;
      next_cycle();
      at_sample();
      check("ar_post_busy", 32'(busy), 32'd0);
      check("ar_post_ctl", 32'(ctl), 32'(CTL_NONE));
      next_cycle();
      dmem_valid_m = 1;
      next_cycle();
      dmem_ready = 1;
      at_sample();
      check("ar_run_busy", 32'(busy), 32'd1);
      check("ar_run_stall_cnt", stall_cnt, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
